// File: rtl/stu_rw_set_tracker.sv
// stu_rw_set_tracker: per-core speculative read-set tracking with master-store conflict and overflow flags
module stu_rw_set_tracker #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W = 32,
  parameter int LINE_OFFSET_W = 6,
  parameter int READ_SET_DEPTH = 16,
  parameter bit OVERFLOW_VIOL = 1'b1,
  localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1,
  localparam int CW = $clog2(READ_SET_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CORES-1:0]      spec_active_in,
  input  logic [IW-1:0]             master_core_id_in,
  input  logic [NUM_CORES*ADDR_W-1:0] core_mem_pa_in,
  input  logic [NUM_CORES-1:0]      core_mem_is_store_in,
  input  logic [NUM_CORES-1:0]      core_mem_valid_in,
  input  logic [NUM_CORES-1:0]      squash_in,
  input  logic [NUM_CORES-1:0]      commit_in,
  output logic [NUM_CORES-1:0]      violation_out,
  output logic [NUM_CORES-1:0]      overflow_out,
  output logic                      violation_any_out,
  output logic [NUM_CORES*CW-1:0]   occupancy_out
);
  localparam int TW = ADDR_W - LINE_OFFSET_W;
  logic [TW-1:0] tag_q [NUM_CORES][READ_SET_DEPTH];
  logic [TW-1:0] tag_d [NUM_CORES][READ_SET_DEPTH];
  logic [CW-1:0] cnt_q [NUM_CORES];
  logic [CW-1:0] cnt_d [NUM_CORES];
  logic [NUM_CORES-1:0] viol_q, viol_d, ovf_q, ovf_d;
  logic any_q, any_d;
  logic [TW-1:0] m_tag, t;
  logic m_st, act, ld, present, hit;
  logic unused_pa;
  assign unused_pa = ^core_mem_pa_in;
  always_comb begin
    tag_d = tag_q;
    cnt_d = cnt_q;
    viol_d = viol_q;
    ovf_d = ovf_q;
    m_tag = '0;
    m_st = 1'b0;
    act = 1'b0;
    ld = 1'b0;
    t = '0;
    present = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < NUM_CORES; i++)
      if (IW'(i) == master_core_id_in) begin
        m_tag = core_mem_pa_in[i*ADDR_W+LINE_OFFSET_W +: TW];
        m_st = core_mem_valid_in[i] & core_mem_is_store_in[i];
      end
    for (int i = 0; i < NUM_CORES; i++) begin
      act = spec_active_in[i] & (IW'(i) != master_core_id_in);
      ld = act & core_mem_valid_in[i] & ~core_mem_is_store_in[i];
      t = core_mem_pa_in[i*ADDR_W+LINE_OFFSET_W +: TW];
      present = 1'b0;
      hit = 1'b0;
      for (int j = 0; j < READ_SET_DEPTH; j++)
        if (CW'(j) < cnt_q[i]) begin
          present = present | (tag_q[i][j] == t);
          hit = hit | (tag_q[i][j] == m_tag);
        end
      hit = act & m_st & (hit | (ld & (t == m_tag)));
      if (squash_in[i] | commit_in[i]) begin
        cnt_d[i] = '0;
        viol_d[i] = 1'b0;
        ovf_d[i] = 1'b0;
      end else begin
        if (ld & ~present & (cnt_q[i] == CW'(READ_SET_DEPTH))) begin
          ovf_d[i] = 1'b1;
          viol_d[i] = viol_d[i] | OVERFLOW_VIOL;
        end else if (ld & ~present) begin
          for (int j = 0; j < READ_SET_DEPTH; j++)
            if (CW'(j) == cnt_q[i]) tag_d[i][j] = t;
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
        viol_d[i] = viol_d[i] | hit;
      end
    end
    any_d = |viol_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tag_q <= '{default: '0};
      cnt_q <= '{default: '0};
      viol_q <= '0;
      ovf_q <= '0;
      any_q <= 1'b0;
    end else begin
      tag_q <= tag_d;
      cnt_q <= cnt_d;
      viol_q <= viol_d;
      ovf_q <= ovf_d;
      any_q <= any_d;
    end
  always_comb
    for (int i = 0; i < NUM_CORES; i++) occupancy_out[i*CW +: CW] = cnt_q[i];
  assign violation_out = viol_q;
  assign overflow_out = ovf_q;
  assign violation_any_out = any_q;
endmodule
